// File: rtl/multicycle_control_unit.sv
// Multicycle control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT) with registered datapath controls.
// Defining CU_SHIFT_EXT_EN adds the shift/rotate opcodes 0x0C-0x0F; otherwise they fault as illegal.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 8,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               INSTR_VALID,
    input  logic [31:0]        INSTRUCTION,
    input  logic               ZERO,
    input  logic               BUSYWAIT,
    output logic               IR_LOAD,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               MUX_IMM,
    output logic               MUX_NEG,
    output logic               MUX_MEM,
    output logic               WRITE,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [1:0]         PC_SRC,
    output logic               PC_EN,
    output logic [1:0]         FAULT
);

    generate
        if (ALUOP_W < 3) begin : g_bad_aluop_w
            $error("multicycle_control_unit: ALUOP_W must be at least 3");
        end
        if (OPCODE_W < 4 || OPCODE_W > 31) begin : g_bad_opcode_w
            $error("multicycle_control_unit: OPCODE_W must be within 4..31");
        end
    endgenerate

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    localparam logic [OPCODE_W-1:0] OP_LOADI = OPCODE_W'(8'h00);
    localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(8'h01);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(8'h02);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(8'h03);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(8'h04);
    localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(8'h05);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(8'h06);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(8'h07);
    localparam logic [OPCODE_W-1:0] OP_LWD   = OPCODE_W'(8'h08);
    localparam logic [OPCODE_W-1:0] OP_LWI   = OPCODE_W'(8'h09);
    localparam logic [OPCODE_W-1:0] OP_SWD   = OPCODE_W'(8'h0A);
    localparam logic [OPCODE_W-1:0] OP_SWI   = OPCODE_W'(8'h0B);
`ifdef CU_SHIFT_EXT_EN
    localparam logic [OPCODE_W-1:0] OP_SLL   = OPCODE_W'(8'h0C);
    localparam logic [OPCODE_W-1:0] OP_SRL   = OPCODE_W'(8'h0D);
    localparam logic [OPCODE_W-1:0] OP_SRA   = OPCODE_W'(8'h0E);
    localparam logic [OPCODE_W-1:0] OP_ROR   = OPCODE_W'(8'h0F);
`endif

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic                ir_load_q, ir_load_d;
    logic [2:0]          aluop_q, aluop_d;
    logic                imm_q, imm_d;
    logic                neg_q, neg_d;
    logic                mux_mem_q, mux_mem_d;
    logic                write_q, write_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [1:0]          pc_src_q, pc_src_d;
    logic                pc_en_q, pc_en_d;
    logic [1:0]          fault_q, fault_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic                timeout_hit;

    logic       dec_legal, dec_imm, dec_neg, dec_wr;
    logic       dec_load, dec_store, dec_jump, dec_beq;
    logic [2:0] dec_aluop;

    // Operand bits below the opcode field belong to the datapath, not to this unit.
    logic unused_instr_bits;
    assign unused_instr_bits = ^INSTRUCTION[31-OPCODE_W:0];

    // Opcode classification from the latched opcode; stable for the whole instruction.
    always_comb begin
        dec_legal = 1'b1;
        dec_aluop = 3'b000;
        dec_imm   = 1'b0;
        dec_neg   = 1'b0;
        dec_wr    = 1'b0;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        dec_jump  = 1'b0;
        dec_beq   = 1'b0;
        case (opcode_q)
            OP_LOADI: begin dec_imm = 1'b1; dec_wr = 1'b1; end
            OP_MOV:   begin dec_wr = 1'b1; end
            OP_ADD:   begin dec_aluop = 3'b001; dec_wr = 1'b1; end
            OP_SUB:   begin dec_aluop = 3'b001; dec_neg = 1'b1; dec_wr = 1'b1; end
            OP_AND:   begin dec_aluop = 3'b010; dec_wr = 1'b1; end
            OP_OR:    begin dec_aluop = 3'b011; dec_wr = 1'b1; end
            OP_J:     begin dec_jump = 1'b1; end
            OP_BEQ:   begin dec_aluop = 3'b001; dec_neg = 1'b1; dec_beq = 1'b1; end
            OP_LWD:   begin dec_wr = 1'b1; dec_load = 1'b1; end
            OP_LWI:   begin dec_imm = 1'b1; dec_wr = 1'b1; dec_load = 1'b1; end
            OP_SWD:   begin dec_store = 1'b1; end
            OP_SWI:   begin dec_imm = 1'b1; dec_store = 1'b1; end
`ifdef CU_SHIFT_EXT_EN
            OP_SLL:   begin dec_aluop = 3'b100; dec_imm = 1'b1; dec_wr = 1'b1; end
            OP_SRL:   begin dec_aluop = 3'b101; dec_imm = 1'b1; dec_wr = 1'b1; end
            OP_SRA:   begin dec_aluop = 3'b110; dec_imm = 1'b1; dec_wr = 1'b1; end
            OP_ROR:   begin dec_aluop = 3'b111; dec_imm = 1'b1; dec_wr = 1'b1; end
`endif
            default:  dec_legal = 1'b0;
        endcase
    end

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == CNT_LIMIT);

    // Every output is registered for the state being entered, so strobes are glitch-free.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        ir_load_d   = 1'b0;
        aluop_d     = aluop_q;
        imm_d       = imm_q;
        neg_d       = neg_q;
        mux_mem_d   = 1'b0;
        write_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        pc_src_d    = 2'b00;
        pc_en_d     = 1'b0;
        fault_d     = fault_q;
        cnt_d       = '0;
        case (state_q)
            S_FETCH: begin
                // IR_LOAD is raised for one FETCH cycle, then the sequencer moves on.
                if (ir_load_q) begin
                    state_d = S_DECODE;
                end else if (INSTR_VALID) begin
                    ir_load_d = 1'b1;
                    opcode_d  = INSTRUCTION[31 -: OPCODE_W];
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    state_d = S_HALT;
                    fault_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                    aluop_d = dec_aluop;
                    imm_d   = dec_imm;
                    neg_d   = dec_neg;
                end
            end
            S_EXEC: begin
                if (dec_load || dec_store) begin
                    state_d     = S_MEM;
                    mem_read_d  = dec_load;
                    mem_write_d = dec_store;
                end else begin
                    state_d  = S_WB;
                    write_d  = dec_wr;
                    pc_en_d  = 1'b1;
                    pc_src_d = dec_jump ? 2'b01 : ((dec_beq && ZERO) ? 2'b10 : 2'b00);
                end
            end
            S_MEM: begin
                if (BUSYWAIT) begin
                    if (timeout_hit) begin
                        state_d = S_HALT;
                        fault_d = 2'b10;
                        aluop_d = 3'b000;
                        imm_d   = 1'b0;
                        neg_d   = 1'b0;
                    end else begin
                        cnt_d       = cnt_inc;
                        mem_read_d  = dec_load;
                        mem_write_d = dec_store;
                    end
                end else begin
                    state_d   = S_WB;
                    write_d   = dec_wr;
                    mux_mem_d = dec_load;
                    pc_en_d   = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                aluop_d = 3'b000;
                imm_d   = 1'b0;
                neg_d   = 1'b0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_FETCH;
            opcode_q    <= '0;
            ir_load_q   <= 1'b0;
            aluop_q     <= 3'b000;
            imm_q       <= 1'b0;
            neg_q       <= 1'b0;
            mux_mem_q   <= 1'b0;
            write_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 2'b00;
            pc_en_q     <= 1'b0;
            fault_q     <= 2'b00;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            ir_load_q   <= ir_load_d;
            aluop_q     <= aluop_d;
            imm_q       <= imm_d;
            neg_q       <= neg_d;
            mux_mem_q   <= mux_mem_d;
            write_q     <= write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            pc_src_q    <= pc_src_d;
            pc_en_q     <= pc_en_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign IR_LOAD   = ir_load_q;
    assign ALUOP     = ALUOP_W'(aluop_q);
    assign MUX_IMM   = imm_q;
    assign MUX_NEG   = neg_q;
    assign MUX_MEM   = mux_mem_q;
    assign WRITE     = write_q;
    assign MEM_READ  = mem_read_q;
    assign MEM_WRITE = mem_write_q;
    assign PC_SRC    = pc_src_q;
    assign PC_EN     = pc_en_q;
    assign FAULT     = fault_q;

endmodule
